// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared types and constants for the grid paint writer.
package grid_pkg;

  localparam int ADDR_W     = 12;
  localparam int VAL_W      = 4;
  localparam int GRID_CELLS = 3072;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [VAL_W-1:0]  val;
  } paint_req_t;

  typedef enum logic { RUN = 1'b0, SWEEP = 1'b1 } gpw_state_t;
  typedef enum logic { PLAY = 1'b0, WALL = 1'b1 } chan_t;

endpackage

// File: rtl/grid_paint_fifo.sv
// rtl/grid_paint_fifo.sv - synchronous FIFO of paint requests with flush.
module grid_paint_fifo
  import grid_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  paint_req_t       din,
  input  logic             pop,
  output paint_req_t       dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  paint_req_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset; only the pointers and level define validity.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/grid_paint_writer.sv
// rtl/grid_paint_writer.sv - arbitrates player/wall paints into a FIFO and drains to grid RAM.
// Optional GRID_BOUNDS_CHECK_EN drops out-of-range requests and counts them.
module grid_paint_writer
  import grid_pkg::*;
#(
  parameter int               DEPTH      = 8,
  parameter int               GRID_CELLS = grid_pkg::GRID_CELLS,
  parameter logic [VAL_W-1:0] CLEAR_VAL  = 4'h0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              play_valid,
  output logic              play_ready,
  input  logic [ADDR_W-1:0] play_addr,
  input  logic [VAL_W-1:0]  play_val,
  input  logic              wall_valid,
  output logic              wall_ready,
  input  logic [ADDR_W-1:0] wall_addr,
  input  logic [VAL_W-1:0]  wall_val,
  input  logic              clear_req,
  input  logic              grid_wr_allow,
  output logic              clear_busy,
  output logic              wren_gridData,
  output logic [ADDR_W-1:0] wraddress_gridData,
  output logic [VAL_W-1:0]  data_gridData,
  output logic [3:0]        fifo_level,
  output logic [7:0]        drop_count
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(GRID_CELLS - 1);

  gpw_state_t       state;
  chan_t            rr_pref;
  logic [ADDR_W-1:0] sweep_cnt;

  logic             run;
  logic             accept_ok;
  logic             play_grant;
  logic             wall_grant;
  logic             in_range;
  paint_req_t       grant_req;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic             fifo_full;
  logic             fifo_empty;
  paint_req_t       fifo_head;
  logic [LVL_W-1:0] fifo_lvl;

  // The non-preferred channel yields only when the preferred one is actually asking.
  always_comb begin
    run        = (state == RUN);
    accept_ok  = run & ~clear_req & ~fifo_full;
    play_ready = accept_ok & ~(wall_valid & (rr_pref == WALL));
    wall_ready = accept_ok & ~(play_valid & (rr_pref == PLAY));
    play_grant = play_valid & play_ready;
    wall_grant = wall_valid & wall_ready;
    grant_req  = play_grant ? '{addr: play_addr, val: play_val}
                            : '{addr: wall_addr, val: wall_val};
    fifo_push  = (play_grant | wall_grant) & in_range;
    fifo_pop   = run & ~clear_req & grid_wr_allow & ~fifo_empty;
    fifo_flush = run & clear_req;
  end

`ifdef GRID_BOUNDS_CHECK_EN
  assign in_range = (32'(grant_req.addr) < GRID_CELLS);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      drop_count <= 8'h00;
    end else if ((play_grant | wall_grant) & ~in_range & (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`else
  assign in_range   = 1'b1;
  assign drop_count = 8'h00;
`endif

  grid_paint_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .flush  (fifo_flush),
    .push   (fifo_push),
    .din    (grant_req),
    .pop    (fifo_pop),
    .dout   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_lvl)
  );

  assign fifo_level = 4'(fifo_lvl);
  assign clear_busy = (state == SWEEP);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state              <= RUN;
      rr_pref            <= PLAY;
      sweep_cnt          <= '0;
      wren_gridData      <= 1'b0;
      wraddress_gridData <= '0;
      data_gridData      <= '0;
    end else begin
      wren_gridData <= 1'b0;
      if (play_grant)      rr_pref <= WALL;
      else if (wall_grant) rr_pref <= PLAY;

      case (state)
        RUN: begin
          if (clear_req) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
          end else if (fifo_pop) begin
            wren_gridData      <= 1'b1;
            wraddress_gridData <= fifo_head.addr;
            data_gridData      <= fifo_head.val;
          end
        end
        SWEEP: begin
          if (grid_wr_allow) begin
            wren_gridData      <= 1'b1;
            wraddress_gridData <= sweep_cnt;
            data_gridData      <= CLEAR_VAL;
            if (sweep_cnt == LAST_CELL) begin
              state     <= RUN;
              sweep_cnt <= '0;
            end else begin
              sweep_cnt <= sweep_cnt + ADDR_W'(1);
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_paint_writer.sv
// tb/tb_grid_paint_writer.sv - directed self-checking bench for grid_paint_writer.
module tb_grid_paint_writer;

  logic        clock = 1'b0;
  logic        resetn;
  logic        play_valid, wall_valid;
  logic        play_ready, wall_ready;
  logic [11:0] play_addr, wall_addr;
  logic [3:0]  play_val, wall_val;
  logic        clear_req, grid_wr_allow;
  logic        clear_busy, wren_gridData;
  logic [11:0] wraddress_gridData;
  logic [3:0]  data_gridData;
  logic [3:0]  fifo_level;
  logic [7:0]  drop_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_play = 0;
  int hs_wall = 0;
  int busy_cnt = 0;
  logic [15:0] wr_q[$];
  int          wr_cyc[$];
  logic        grant_q[$];

  grid_paint_writer dut (
    .clock              (clock),
    .resetn             (resetn),
    .play_valid         (play_valid),
    .play_ready         (play_ready),
    .play_addr          (play_addr),
    .play_val           (play_val),
    .wall_valid         (wall_valid),
    .wall_ready         (wall_ready),
    .wall_addr          (wall_addr),
    .wall_val           (wall_val),
    .clear_req          (clear_req),
    .grid_wr_allow      (grid_wr_allow),
    .clear_busy         (clear_busy),
    .wren_gridData      (wren_gridData),
    .wraddress_gridData (wraddress_gridData),
    .data_gridData      (data_gridData),
    .fifo_level         (fifo_level),
    .drop_count         (drop_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (wren_gridData) begin
      wr_q.push_back({wraddress_gridData, data_gridData});
      wr_cyc.push_back(cyc);
    end
    if (play_valid && play_ready) begin hs_play++; grant_q.push_back(1'b0); end
    if (wall_valid && wall_ready) begin hs_wall++; grant_q.push_back(1'b1); end
    if (clear_busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_log();
    wr_q.delete();
    wr_cyc.delete();
    grant_q.delete();
    hs_play = 0;
    hs_wall = 0;
    busy_cnt = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    play_valid = 0; wall_valid = 0; clear_req = 0; grid_wr_allow = 0;
    play_addr = 0; play_val = 0; wall_addr = 0; wall_val = 0;
    tick(2);
    resetn = 1'b1;
    clear_log();
  endtask

  initial begin
    int n;
    int bad;
    logic [3:0] gseq;

    // T1: reset asserted while a drain is in progress
    do_reset();
    play_valid = 1;
    for (int i = 0; i < 3; i++) begin
      play_addr = 12'(12'h0A0 + i); play_val = 4'(i + 1);
      tick();
    end
    play_valid = 0;
    check("t1_level_pre", fifo_level, 3);
    grid_wr_allow = 1;
    tick();
    check("t1_wren_pre", wren_gridData, 1);
    check("t1_addr_pre", wraddress_gridData, 12'h0A0);
    resetn = 1'b0;
    #1;
    check("t1_wren", wren_gridData, 0);
    check("t1_addr", wraddress_gridData, 0);
    check("t1_data", data_gridData, 0);
    check("t1_level", fifo_level, 0);
    check("t1_busy", clear_busy, 0);
    check("t1_play_rdy", play_ready, 1);
    check("t1_wall_rdy", wall_ready, 1);
    check("t1_drop", drop_count, 0);

    // T2: single play request, latency and content
    do_reset();
    grid_wr_allow = 1;
    play_valid = 1; play_addr = 12'h123; play_val = 4'h5;
    tick();
    play_valid = 0;
    check("t2_wren_e0", wren_gridData, 0);
    check("t2_level_e0", fifo_level, 1);
    tick();
    check("t2_wren_e1", wren_gridData, 1);
    check("t2_addr", wraddress_gridData, 12'h123);
    check("t2_data", data_gridData, 4'h5);
    check("t2_level_e1", fifo_level, 0);
    tick();
    check("t2_wren_e2", wren_gridData, 0);
    check("t2_addr_hold", wraddress_gridData, 12'h123);
    check("t2_nwrites", wr_q.size(), 1);

    // T3: both channels contend for 4 cycles
    do_reset();
    grid_wr_allow = 1;
    play_valid = 1; wall_valid = 1; play_val = 4'h1; wall_val = 4'h2;
    for (int i = 0; i < 4; i++) begin
      play_addr = 12'(12'h010 + i);
      wall_addr = 12'(12'h020 + i);
      tick();
    end
    play_valid = 0; wall_valid = 0;
    tick(4);
    check("t3_hs_play", hs_play, 2);
    check("t3_hs_wall", hs_wall, 2);
    gseq = 4'hF;
    if (grant_q.size() == 4) gseq = {grant_q[0], grant_q[1], grant_q[2], grant_q[3]};
    check("t3_grant_seq", gseq, 4'b0101);
    check("t3_nwrites", wr_q.size(), 4);
    if (wr_q.size() == 4) begin
      check("t3_wr0", wr_q[0], {12'h010, 4'h1});
      check("t3_wr1", wr_q[1], {12'h021, 4'h2});
      check("t3_wr2", wr_q[2], {12'h012, 4'h1});
      check("t3_wr3", wr_q[3], {12'h023, 4'h2});
    end

    // T4: fill with writes blocked, then drain
    do_reset();
    play_valid = 1;
    for (int i = 0; i < 10; i++) begin
      play_addr = 12'(12'h100 + i); play_val = 4'(i);
      tick();
    end
    check("t4_hs", hs_play, 8);
    check("t4_level_full", fifo_level, 8);
    check("t4_ready_full", play_ready, 0);
    check("t4_no_write", wr_q.size(), 0);
    play_valid = 0;
    grid_wr_allow = 1;
    tick(10);
    check("t4_nwrites", wr_q.size(), 8);
    if (wr_q.size() == 8) begin
      check("t4_consecutive", wr_cyc[7] - wr_cyc[0], 7);
      bad = 0;
      for (int i = 0; i < 8; i++)
        if (wr_q[i] !== {12'(12'h100 + i), 4'(i)}) bad++;
      check("t4_order", bad, 0);
    end
    check("t4_level_empty", fifo_level, 0);

    // T5: clear sweep discards queued entries
    do_reset();
    play_valid = 1; play_val = 4'hA;
    for (int i = 0; i < 3; i++) begin
      play_addr = 12'(12'h300 + i);
      tick();
    end
    play_valid = 0;
    check("t5_level_q", fifo_level, 3);
    clear_req = 1;
    #1;
    check("t5_rdy_clr", play_ready, 0);
    tick();
    clear_req = 0;
    grid_wr_allow = 1;
    check("t5_busy_start", clear_busy, 1);
    check("t5_flushed", fifo_level, 0);
    n = 0;
    while (clear_busy && n < 5000) begin
      clear_req = (n == 100);
      play_valid = (n == 50);
      #1;
      if (n == 50) check("t5_rdy_sweep", play_ready, 0);
      tick();
      n++;
    end
    clear_req = 0; play_valid = 0;
    check("t5_timeout", n < 5000, 1);
    tick(5);
    check("t5_busy_cycles", busy_cnt, 3072);
    check("t5_nwrites", wr_q.size(), 3072);
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++)
      if (wr_q[i] !== {12'(i), 4'h0}) bad++;
    check("t5_sweep_seq", bad, 0);
    check("t5_busy_end", clear_busy, 0);
    check("t5_level_end", fifo_level, 0);
    check("t5_run_rdy", play_ready, 1);

    // T6: out-of-range address handling
    do_reset();
    grid_wr_allow = 1;
    play_valid = 1; play_addr = 12'hC00; play_val = 4'h7;
    tick();
    play_valid = 0;
    tick(3);
    check("t6_hs", hs_play, 1);
`ifdef GRID_BOUNDS_CHECK_EN
    check("t6_no_write", wr_q.size(), 0);
    check("t6_drop1", drop_count, 1);
    play_valid = 1; play_addr = 12'hBFF; play_val = 4'h3;
    tick();
    play_valid = 0;
    tick(3);
    check("t6_inrange_n", wr_q.size(), 1);
    if (wr_q.size() == 1) check("t6_inrange_wr", wr_q[0], {12'hBFF, 4'h3});
    play_valid = 1; play_addr = 12'hFFF;
    tick(254);
    check("t6_drop255", drop_count, 255);
    tick();
    play_valid = 0;
    tick();
    check("t6_drop_sat", drop_count, 255);
    check("t6_no_extra", wr_q.size(), 1);
`else
    check("t6_nwrites", wr_q.size(), 1);
    if (wr_q.size() == 1) check("t6_wr", wr_q[0], {12'hC00, 4'h7});
    check("t6_drop0", drop_count, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
